arith_engine: RTL and testbench

ARITH_ENGINE -- requirements
Module: arith_engine

---
 rtl/arith_pkg.sv | 15 +
 rtl/shift_add_multiplier.sv | 49 ++++
 rtl/arith_engine.sv | 98 +++++++++
 tb/tb_arith_engine.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared op encodings and FSM state type for the arithmetic engine.
package arith_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_MUL  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/shift_add_multiplier.sv
// Iterative unsigned multiplier, one partial product per step; WIDTH steps after load.
// No backpressure: the caller owns step sequencing; fin flags the final step.
module shift_add_multiplier
  import arith_pkg::*;
#(
  parameter int WIDTH = 17
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 step,
  input  logic [WIDTH-1:0]     mcand_in,
  input  logic [WIDTH-1:0]     mplier_in,
  output logic [2*WIDTH-1:0]   product,
  output logic                 fin
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;

  // product already includes the current step's partial, so the caller can
  // capture the final value on the same edge the last step retires.
  assign product = acc + (mplier[0] ? mcand : '0);
  assign fin     = step && (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, mcand_in};
      mplier <= mplier_in;
      cnt    <= '0;
    end else if (step) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/arith_engine.sv
// ADD/SUB/MUL engine: ADD/SUB/reserved finish in 1 cycle, MUL in WIDTH cycles.
// start is honoured only in IDLE; requests while busy are dropped, never queued.
module arith_engine
  import arith_pkg::*;
#(
  parameter int WIDTH = 17
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [WIDTH-1:0]     num_1,
  input  logic [WIDTH-1:0]     num_2,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result,
  output logic                 negative,
  output logic                 op_err
);

  state_t             state;
  logic               mul_load;
  logic               mul_step;
  logic               mul_fin;
  logic [2*WIDTH-1:0] mul_product;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;

  assign sum      = {1'b0, num_1} + {1'b0, num_2};
  // Bit WIDTH of the extended difference is the borrow, i.e. num_1 < num_2.
  assign diff     = {1'b0, num_1} - {1'b0, num_2};

  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_DONE);
  assign mul_load = (state == ST_IDLE) && start && (op == OP_MUL);
  assign mul_step = (state == ST_MUL);

  shift_add_multiplier #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst       (rst),
    .load      (mul_load),
    .step      (mul_step),
    .mcand_in  (num_1),
    .mplier_in (num_2),
    .product   (mul_product),
    .fin       (mul_fin)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      result   <= '0;
      negative <= 1'b0;
      op_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            case (op)
              OP_ADD: begin
                result   <= {{(WIDTH-1){1'b0}}, sum};
                negative <= 1'b0;
                op_err   <= 1'b0;
                state    <= ST_DONE;
              end
              OP_SUB: begin
                result   <= {{(WIDTH-1){diff[WIDTH]}}, diff};
                negative <= diff[WIDTH];
                op_err   <= 1'b0;
                state    <= ST_DONE;
              end
              OP_MUL: begin
                state    <= ST_MUL;
              end
              default: begin
                result   <= '0;
                negative <= 1'b0;
                op_err   <= 1'b1;
                state    <= ST_DONE;
              end
            endcase
          end
        end
        ST_MUL: begin
          if (mul_fin) begin
            result   <= mul_product;
            negative <= 1'b0;
            op_err   <= 1'b0;
            state    <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arith_engine.sv
// Scoreboard bench for arith_engine at WIDTH=17: tasks push expectations, a done monitor pops them.
module tb_arith_engine;

  localparam int W = 17;
  localparam logic [W-1:0] MAXV = {W{1'b1}};

  typedef struct {
    logic [2*W-1:0] res;
    logic           neg;
    logic           err;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [1:0]     op = 2'b00;
  logic [W-1:0]   num_1 = '0;
  logic [W-1:0]   num_2 = '0;
  logic           busy;
  logic           done;
  logic [2*W-1:0] result;
  logic           negative;
  logic           op_err;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   done_count = 0;

  arith_engine #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .num_1    (num_1),
    .num_2    (num_2),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .negative (negative),
    .op_err   (op_err)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [2*W-1:0] xa;
    logic [2*W-1:0] xb;
    xa = {{W{1'b0}}, a};
    xb = {{W{1'b0}}, b};
    e.neg = 1'b0;
    e.err = 1'b0;
    case (o)
      2'b00: e.res = xa + xb;
      2'b01: begin e.res = xa - xb; e.neg = (a < b); end
      2'b10: e.res = xa * xb;
      default: begin e.res = '0; e.err = 1'b1; end
    endcase
    return e;
  endfunction

  // Result checker: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      done_count++;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: done=1 with no request outstanding, result=%0h", result);
      end else begin
        mon_e = sb_q.pop_front();
        if (result !== mon_e.res) begin
          errors++;
          $display("FAIL result: got %0h expected %0h", result, mon_e.res);
        end
        checks++;
        if (negative !== mon_e.neg) begin
          errors++;
          $display("FAIL negative: got %b expected %b", negative, mon_e.neg);
        end
        checks++;
        if (op_err !== mon_e.err) begin
          errors++;
          $display("FAIL op_err: got %b expected %b", op_err, mon_e.err);
        end
      end
    end
  end

  // exp_edges: rising edges after the accepting edge before done is visible.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int exp_edges, input int exp_busy, input string name);
    int   edges;
    int   bcnt;
    exp_t e;
    e = model(o, a, b);
    @(negedge clk);
    start = 1'b1; op = o; num_1 = a; num_2 = b;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    edges = 0;
    bcnt  = 0;
    while (!done && edges < 100) begin
      if (busy) bcnt++;
      @(negedge clk);
      edges++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_timeout: no done within %0d cycles", name, edges);
    end else begin
      if (busy) bcnt++;
      if (edges !== exp_edges) begin
        errors++;
        $display("FAIL %s_latency: got %0d edges expected %0d", name, edges, exp_edges);
      end
      checks++;
      if (bcnt !== exp_busy) begin
        errors++;
        $display("FAIL %s_busy_cycles: got %0d expected %0d", name, bcnt, exp_busy);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_pulse: done=%b busy=%b expected 0 0", name, done, busy);
    end
    checks++;
    if (result !== e.res) begin
      errors++;
      $display("FAIL %s_hold: result=%0h expected %0h", name, result, e.res);
    end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({busy, done, result, negative, op_err} !== '0) begin
      errors++;
      $display("FAIL %s: busy=%b done=%b result=%0h neg=%b err=%b expected all 0",
               name, busy, done, result, negative, op_err);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_zero("reset_state");
    rst = 1'b0;
  endtask

  task automatic test_add();
    run_op(2'b00, MAXV, MAXV, 0, 1, "add_max");
    run_op(2'b00, 17'd0, 17'd0, 0, 1, "add_zero");
    run_op(2'b00, 17'd12345, 17'd54321, 0, 1, "add_mid");
  endtask

  task automatic test_sub();
    run_op(2'b01, 17'd5, 17'd9, 0, 1, "sub_neg");
    run_op(2'b01, 17'd9, 17'd5, 0, 1, "sub_pos");
    run_op(2'b01, 17'd0, MAXV, 0, 1, "sub_min");
    run_op(2'b01, MAXV, MAXV, 0, 1, "sub_eq");
  endtask

  task automatic test_mul();
    run_op(2'b10, MAXV, MAXV, W, W + 1, "mul_max");
    run_op(2'b10, 17'd0, MAXV, W, W + 1, "mul_zero");
    run_op(2'b10, 17'd1, 17'd77777, W, W + 1, "mul_one");
    for (int i = 0; i < 3; i++)
      run_op(2'b10, W'($urandom), W'($urandom), W, W + 1, "mul_rand");
  endtask

  task automatic test_ignore_start();
    int edges;
    int dc0;
    dc0 = done_count;
    @(negedge clk);
    start = 1'b1; op = 2'b10; num_1 = MAXV; num_2 = 17'd3;
    sb_q.push_back(model(2'b10, MAXV, 17'd3));
    @(negedge clk);
    start = 1'b0;
    edges = 0;
    repeat (4) begin @(negedge clk); edges++; end
    start = 1'b1; op = 2'b00; num_1 = 17'd7; num_2 = 17'd9;
    @(negedge clk);
    edges++;
    start = 1'b0;
    while (!done && edges < 100) begin @(negedge clk); edges++; end
    checks++;
    if (edges !== W) begin
      errors++;
      $display("FAIL ignore_latency: got %0d edges expected %0d", edges, W);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (done_count - dc0 !== 1 || sb_q.size() !== 0) begin
      errors++;
      $display("FAIL ignore_single_done: got %0d dones, %0d pending expected 1, 0",
               done_count - dc0, sb_q.size());
    end
  endtask

  task automatic test_reset_mid_mul();
    int dc0;
    @(negedge clk);
    start = 1'b1; op = 2'b10; num_1 = MAXV; num_2 = MAXV;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    dc0 = done_count;
    rst = 1'b1;
    #1;
    check_zero("rst_mid_mul_immediate");
    repeat (2) @(negedge clk);
    check_zero("rst_mid_mul_held");
    rst = 1'b0;
    repeat (W + 5) @(negedge clk);
    checks++;
    if (done_count !== dc0 || result !== '0) begin
      errors++;
      $display("FAIL rst_abort: got %0d dones result=%0h expected 0 0", done_count - dc0, result);
    end
    run_op(2'b00, 17'd1, 17'd2, 0, 1, "add_after_rst");
  endtask

  task automatic test_reserved();
    run_op(2'b11, 17'd100, 17'd200, 0, 1, "rsv");
    run_op(2'b00, 17'd0, 17'd0, 0, 1, "add_clears_err");
  endtask

  task automatic test_back_to_back();
    logic [1:0] o;
    for (int i = 0; i < 8; i++) begin
      o = 2'($urandom_range(0, 3));
      run_op(o, W'($urandom), W'($urandom), (o == 2'b10) ? W : 0, (o == 2'b10) ? W + 1 : 1, "b2b");
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_ignore_start();
    test_reset_mid_mul();
    test_reserved();
    test_back_to_back();
    repeat (3) @(negedge clk);
    checks++;
    if (sb_q.size() !== 0) begin
      errors++;
      $display("FAIL pending_results: got %0d outstanding expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
